// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter
// Purpose  : Shares one single-port 256x240x8 frame-buffer RAM between the
//            PPU pixel writer (through a small FIFO) and the VGA scanline
//            prefetcher, which copies a complete line into the line buffer.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   ppu_wr_valid/_ready   PPU write handshake; ready = FIFO not full
//   ppu_wr_x/_y/_pixel    PPU pixel coordinate and palette index
//   line_req/_y           1-cycle pulse to fetch line line_req_y
//   line_busy/line_done   fetch in progress / 1-cycle completion pulse
//   err_overrun           sticky, line_req while a fetch was in progress
//   lb_we/lb_addr/lb_data line-buffer write port
//   fb_en/fb_we/fb_addr/fb_wdata/fb_rdata   frame-buffer RAM port
// ============================================================================
module fb_port_arbiter #(
    parameter int FIFO_DEPTH     = 4,
    parameter int RD_LATENCY     = 2,
    parameter int WR_SLOT_PERIOD = 8,
    parameter int LINE_W         = 256,
    parameter int LINE_H         = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ppu_wr_valid,
    output logic        ppu_wr_ready,
    input  logic [7:0]  ppu_wr_x,
    input  logic [7:0]  ppu_wr_y,
    input  logic [7:0]  ppu_wr_pixel,
    input  logic        line_req,
    input  logic [7:0]  line_req_y,
    output logic        line_busy,
    output logic        line_done,
    output logic        err_overrun,
    output logic        lb_we,
    output logic [7:0]  lb_addr,
    output logic [7:0]  lb_data,
    output logic        fb_en,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [7:0]  fb_wdata,
    input  logic [7:0]  fb_rdata
);

    localparam int         c_aw     = $clog2(FIFO_DEPTH);
    localparam int         c_cw     = c_aw + 1;
    localparam int         c_rw     = $clog2(WR_SLOT_PERIOD + 1);
    localparam logic [7:0] c_last_x = 8'(LINE_W - 1);
    localparam logic [8:0] c_line_h = 9'(LINE_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [7:0]              y_q, y_d;
    logic                    oor_q, oor_d;
    logic [7:0]              rd_x_q, rd_x_d;
    logic [7:0]              ret_x_q, ret_x_d;
    logic [c_rw-1:0]         rd_run_q, rd_run_d;
    logic [RD_LATENCY-1:0]   vld_q, vld_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    last_q, last_d;
    logic                    lb_we_q, lb_we_d;
    logic [7:0]              lb_addr_q, lb_addr_d;
    logic [7:0]              lb_data_q, lb_data_d;
    logic                    fb_en_q, fb_en_d;
    logic                    fb_we_q, fb_we_d;
    logic [15:0]             fb_addr_q, fb_addr_d;
    logic [7:0]              fb_wdata_q, fb_wdata_d;

    logic [23:0]             mem_q [FIFO_DEPTH];
    logic [c_aw-1:0]         wptr_q, wptr_d;
    logic [c_aw-1:0]         rptr_q, rptr_d;
    logic [c_cw-1:0]         cnt_q, cnt_d;
    logic                    rdy_q, rdy_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_push, w_pop, w_full, w_ne, w_ret, w_accept, w_wr_go, w_slot;
    logic [23:0] w_head;
    logic        w_head_ok;

    assign w_push    = ppu_wr_valid && rdy_q;
    assign w_full    = (cnt_q == c_cw'(FIFO_DEPTH));
    assign w_ne      = (cnt_q != '0);
    assign w_head    = mem_q[rptr_q];
    assign w_head_ok = ({1'b0, w_head[23:16]} < c_line_h);
    assign w_ret     = vld_q[RD_LATENCY-1];
    assign w_accept  = line_req && (state_q == S_IDLE);
    // A fetch read may only be displaced by a write when the FIFO is
    // backing up or the read run has used up its allowance.
    assign w_slot    = w_ne && (w_full || (rd_run_q == c_rw'(WR_SLOT_PERIOD)));

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        oor_d      = oor_q;
        rd_x_d     = rd_x_q;
        ret_x_d    = ret_x_q;
        rd_run_d   = rd_run_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q | (line_req && (state_q != S_IDLE));
        last_d     = 1'b0;
        lb_we_d    = 1'b0;
        lb_addr_d  = lb_addr_q;
        lb_data_d  = lb_data_q;
        fb_en_d    = 1'b0;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        w_wr_go    = 1'b0;
        // Track reads at the RAM port, so the pipeline lines up with fb_rdata.
        vld_d      = (vld_q << 1) | RD_LATENCY'(fb_en_q & ~fb_we_q);

        if (w_ret) begin
            lb_we_d   = 1'b1;
            lb_addr_d = ret_x_q;
            lb_data_d = fb_rdata;
            last_d    = (ret_x_q == c_last_x);
            ret_x_d   = ret_x_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                w_wr_go = w_ne;
                if (w_accept) begin
                    state_d  = S_FETCH;
                    y_d      = line_req_y;
                    oor_d    = ({1'b0, line_req_y} >= c_line_h);
                    rd_x_d   = 8'd0;
                    ret_x_d  = 8'd0;
                    rd_run_d = '0;
                    busy_d   = 1'b1;
                end
            end
            S_FETCH: begin
                if (oor_q) begin
                    // Out-of-range line: fill with zeros, RAM stays free for writes.
                    w_wr_go   = w_ne;
                    lb_we_d   = 1'b1;
                    lb_addr_d = ret_x_q;
                    lb_data_d = 8'd0;
                    last_d    = (ret_x_q == c_last_x);
                    ret_x_d   = ret_x_q + 8'd1;
                    if (ret_x_q == c_last_x) begin
                        state_d = S_DRAIN;
                    end
                end else if (w_slot) begin
                    w_wr_go  = 1'b1;
                    rd_run_d = '0;
                end else begin
                    fb_en_d   = 1'b1;
                    fb_we_d   = 1'b0;
                    fb_addr_d = {y_q, rd_x_q};
                    rd_x_d    = rd_x_q + 8'd1;
                    rd_run_d  = w_ne ? rd_run_q + c_rw'(1) : '0;
                    if (rd_x_q == c_last_x) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_wr_go = w_ne;
                // last_q marks the cycle lb_we is high for the final pixel.
                if (last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Writes pop the FIFO head; off-screen entries are discarded silently.
        w_pop = w_wr_go;
        if (w_wr_go && w_head_ok) begin
            fb_en_d    = 1'b1;
            fb_we_d    = 1'b1;
            fb_addr_d  = {w_head[23:16], w_head[15:8]};
            fb_wdata_d = w_head[7:0];
        end

        wptr_d = w_push ? wptr_q + c_aw'(1) : wptr_q;
        rptr_d = w_pop  ? rptr_q + c_aw'(1) : rptr_q;
        cnt_d  = cnt_q + c_cw'(w_push) - c_cw'(w_pop);
        rdy_d  = (cnt_d != c_cw'(FIFO_DEPTH));
    end

    // FIFO storage carries no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= {ppu_wr_y, ppu_wr_x, ppu_wr_pixel};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            y_q        <= 8'd0;
            oor_q      <= 1'b0;
            rd_x_q     <= 8'd0;
            ret_x_q    <= 8'd0;
            rd_run_q   <= '0;
            vld_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_addr_q  <= 8'd0;
            lb_data_q  <= 8'd0;
            fb_en_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= 16'd0;
            fb_wdata_q <= 8'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            oor_q      <= oor_d;
            rd_x_q     <= rd_x_d;
            ret_x_q    <= ret_x_d;
            rd_run_q   <= rd_run_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_q     <= last_d;
            lb_we_q    <= lb_we_d;
            lb_addr_q  <= lb_addr_d;
            lb_data_q  <= lb_data_d;
            fb_en_q    <= fb_en_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
        end
    end

    assign ppu_wr_ready = rdy_q;
    assign line_busy    = busy_q;
    assign line_done    = done_q;
    assign err_overrun  = err_q;
    assign lb_we        = lb_we_q;
    assign lb_addr      = lb_addr_q;
    assign lb_data      = lb_data_q;
    assign fb_en        = fb_en_q;
    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_wdata     = fb_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_port_arbiter
// Purpose  : Self-checking bench for fb_port_arbiter with a behavioural RAM,
//            a golden frame-buffer image and write / line-buffer scoreboards.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_port_arbiter;

    localparam int FIFO_DEPTH     = 4;
    localparam int RD_LATENCY     = 2;
    localparam int WR_SLOT_PERIOD = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ppu_wr_valid = 1'b0;
    logic        ppu_wr_ready;
    logic [7:0]  ppu_wr_x = 8'd0, ppu_wr_y = 8'd0, ppu_wr_pixel = 8'd0;
    logic        line_req = 1'b0;
    logic [7:0]  line_req_y = 8'd0;
    logic        line_busy, line_done, err_overrun;
    logic        lb_we;
    logic [7:0]  lb_addr, lb_data;
    logic        fb_en, fb_we;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata, fb_rdata;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .RD_LATENCY     (RD_LATENCY),
        .WR_SLOT_PERIOD (WR_SLOT_PERIOD),
        .LINE_W         (256),
        .LINE_H         (240)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ppu_wr_valid (ppu_wr_valid),
        .ppu_wr_ready (ppu_wr_ready),
        .ppu_wr_x     (ppu_wr_x),
        .ppu_wr_y     (ppu_wr_y),
        .ppu_wr_pixel (ppu_wr_pixel),
        .line_req     (line_req),
        .line_req_y   (line_req_y),
        .line_busy    (line_busy),
        .line_done    (line_done),
        .err_overrun  (err_overrun),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_data      (lb_data),
        .fb_en        (fb_en),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .fb_rdata     (fb_rdata)
    );

    // ------------------------------------------------------------------
    // Behavioural RAM: data valid RD_LATENCY cycles after the read cycle
    // ------------------------------------------------------------------
    logic [7:0] ram  [65536];
    logic [7:0] gold [65536];
    logic [7:0] dq   [RD_LATENCY];

    always @(posedge clk) begin
        if (fb_en && fb_we) ram[fb_addr] <= fb_wdata;
        dq[0] <= ram[fb_addr];
        for (int i = 1; i < RD_LATENCY; i++) dq[i] <= dq[i-1];
    end
    assign fb_rdata = dq[RD_LATENCY-1];

    // ------------------------------------------------------------------
    // Scoreboards and counters
    // ------------------------------------------------------------------
    typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [7:0] x; logic [7:0] d; } lb_t;
    typedef struct {
        logic [7:0]  x, y, pix;
        logic        exp_we;
        logic [15:0] exp_addr;
    } vec_t;

    wr_t wr_q[$];
    lb_t lb_q[$];
    wr_t we_pop;
    lb_t le_pop;

    int total = 0, bad = 0;
    int lb_cnt = 0, done_cnt = 0, fb_en_cnt = 0, rd_cnt = 0;
    int run = 0, max_run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (lb_we) begin
            lb_cnt++;
            if (lb_q.size() == 0) chk("lb_unexpected", 1, 0);
            else begin
                le_pop = lb_q.pop_front();
                chk("lb_addr", lb_addr, le_pop.x);
                chk("lb_data", lb_data, le_pop.d);
            end
        end
        if (line_done) done_cnt++;
        if (fb_en) fb_en_cnt++;
        if (fb_en && !fb_we) begin
            rd_cnt++;
            if (wr_q.size() > 0) begin
                run++;
                if (run > max_run) max_run = run;
            end else run = 0;
        end else run = 0;
        if (fb_en && fb_we) begin
            if (wr_q.size() == 0) chk("fb_wr_unexpected", 1, 0);
            else begin
                we_pop = wr_q.pop_front();
                chk("fb_addr", fb_addr, we_pop.addr);
                chk("fb_wdata", fb_wdata, we_pop.data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic push_pix(input logic [7:0] x, input logic [7:0] y, input logic [7:0] p,
                            input logic exp_we, input logic [15:0] exp_addr);
        int n = 0;
        @(negedge clk);
        ppu_wr_valid = 1'b1; ppu_wr_x = x; ppu_wr_y = y; ppu_wr_pixel = p;
        while (!ppu_wr_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("push_timeout", 1, 0);
        @(posedge clk);
        if (exp_we) begin
            wr_q.push_back('{addr: exp_addr, data: p});
            gold[exp_addr] = p;
        end
        #1 ppu_wr_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] y, input logic overrun);
        lb_t e;
        int  d0, r0, n;
        for (int x = 0; x < 256; x++) begin
            e.x = 8'(x);
            e.d = (y < 240) ? gold[{y, 8'(x)}] : 8'd0;
            lb_q.push_back(e);
        end
        d0 = done_cnt; r0 = rd_cnt;
        @(negedge clk); line_req = 1'b1; line_req_y = y;
        @(negedge clk); line_req = 1'b0;
        chk("busy_set", line_busy, 1);
        if (overrun) begin
            repeat (20) @(negedge clk);
            line_req = 1'b1; line_req_y = y + 8'd2;
            @(negedge clk); line_req = 1'b0;
            chk("err_overrun_set", err_overrun, 1);
        end
        n = 0;
        while ((lb_q.size() != 0 || done_cnt == d0) && n < 3000) begin @(negedge clk); n++; end
        chk("fetch_complete", (n < 3000), 1);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("busy_clr", line_busy, 0);
        chk("fb_reads", rd_cnt - r0, (y < 240) ? 256 : 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t vecs [6];

    initial begin
        int n, snap, d0;
        vecs[0] = '{x: 8'd10,  y: 8'd20,  pix: 8'h3C, exp_we: 1'b1, exp_addr: 16'h140A};
        vecs[1] = '{x: 8'd255, y: 8'd0,   pix: 8'hA5, exp_we: 1'b1, exp_addr: 16'h00FF};
        vecs[2] = '{x: 8'd0,   y: 8'd239, pix: 8'h11, exp_we: 1'b1, exp_addr: 16'hEF00};
        vecs[3] = '{x: 8'd1,   y: 8'd240, pix: 8'h22, exp_we: 1'b0, exp_addr: 16'h0000};
        vecs[4] = '{x: 8'd2,   y: 8'd250, pix: 8'h33, exp_we: 1'b0, exp_addr: 16'h0000};
        vecs[5] = '{x: 8'd7,   y: 8'd255, pix: 8'h44, exp_we: 1'b0, exp_addr: 16'h0000};

        for (int a = 0; a < 65536; a++) begin
            ram[a]  = 8'(a) ^ 8'(a >> 8);
            gold[a] = 8'(a) ^ 8'(a >> 8);
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", ppu_wr_ready, 0);
        chk("rst_fb_en", fb_en, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_busy", line_busy, 0);
        chk("rst_done", line_done, 0);
        chk("rst_err", err_overrun, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", ppu_wr_ready, 1);

        // Line fetch y=5
        do_fetch(8'd5, 1'b0);
        chk("err_clear_t1", err_overrun, 0);

        // PPU write vectors while idle, including off-screen drops
        foreach (vecs[i]) begin
            snap = fb_en_cnt;
            push_pix(vecs[i].x, vecs[i].y, vecs[i].pix, vecs[i].exp_we, vecs[i].exp_addr);
            repeat (3) @(negedge clk);
            chk("wr_within_3", wr_q.size(), 0);
            chk("fb_en_events", fb_en_cnt - snap, vecs[i].exp_we ? 1 : 0);
        end
        chk("ready_after_drops", ppu_wr_ready, 1);
        do_fetch(8'd20, 1'b0);
        do_fetch(8'd239, 1'b0);
        do_fetch(8'd0, 1'b0);

        // Writes competing with a fetch
        max_run = 0;
        fork
            do_fetch(8'd50, 1'b0);
            begin
                repeat (5) @(negedge clk);
                for (int k = 0; k < FIFO_DEPTH; k++)
                    push_pix(8'(3 * k), 8'(100 + k), 8'(8'hC0 + k), 1'b1, {8'(100 + k), 8'(3 * k)});
            end
        join
        n = 0;
        while (wr_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("t3_writes_done", wr_q.size(), 0);
        chk("t3_max_read_run_ok", (max_run <= WR_SLOT_PERIOD + 1), 1);
        do_fetch(8'd100, 1'b0);
        do_fetch(8'd102, 1'b0);

        // Out-of-range line
        do_fetch(8'd240, 1'b0);

        // Overrun during a fetch
        do_fetch(8'd7, 1'b1);
        repeat (5) @(negedge clk);
        chk("err_sticky", err_overrun, 1);

        // Reset in the middle of a fetch
        for (int x = 0; x < 256; x++) lb_q.push_back('{x: 8'(x), d: gold[{8'd30, 8'(x)}]});
        snap = lb_cnt; d0 = done_cnt;
        @(negedge clk); line_req = 1'b1; line_req_y = 8'd30;
        @(negedge clk); line_req = 1'b0;
        n = 0;
        while (lb_cnt - snap < 100 && n < 1000) begin @(negedge clk); n++; end
        chk("t6_reach_x100", (n < 1000), 1);
        reset_n = 1'b0;
        #1 lb_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_busy", line_busy, 0);
        chk("t6_ready", ppu_wr_ready, 1);
        chk("t6_err_cleared", err_overrun, 0);
        do_fetch(8'd31, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
